// File: rtl/y86_fetch_decode_execute.sv
// Single-cycle Y86-64 fetch/decode/execute with register file and condition codes.
// Define Y86_ALU_DEBUG_EN to expose the ALU operands on alu_valA/alu_valB/alu_valC.
module y86_fetch_decode_execute #(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [63:0] RSP_INIT   = 64'd27
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [63:0]             PC,
  input  logic [8*IMEM_BYTES-1:0] imem,
  input  logic [63:0]             valM,
  output logic [3:0]              icode,
  output logic [3:0]              ifun,
  output logic [3:0]              rA,
  output logic [3:0]              rB,
  output logic [63:0]             valC,
  output logic [63:0]             valP,
  output logic [63:0]             valA,
  output logic [63:0]             valB,
  output logic [63:0]             valE,
  output logic                    cnd,
  output logic                    zf,
  output logic                    sf,
  output logic                    of,
  output logic                    imem_error,
  output logic                    instr_valid,
  output logic                    hlt
`ifdef Y86_ALU_DEBUG_EN
  ,
  output logic signed [63:0]      alu_valA,
  output logic signed [63:0]      alu_valB,
  output logic signed [63:0]      alu_valC
`endif
);

  localparam int unsigned AW     = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam int unsigned NBYTES = 10;
  localparam logic [3:0]  RNONE  = 4'hF;
  localparam logic [3:0]  RSP    = 4'h4;

  logic [NBYTES-1:0][7:0] ibyte;
  logic [NBYTES-1:0]      oob;
  logic [63:0]            addr;
  logic                   need_regids;
  logic                   need_valc;
  logic [3:0]             ilen;
  logic [3:0]             src_a;
  logic [3:0]             src_b;
  logic [3:0]             dst_e;
  logic [3:0]             dst_m;
  logic [63:0]            sum;
  logic [63:0]            diff;
  logic                   of_next;
  logic                   wr_ok;
  logic [63:0]            regs [15];

  // Byte fetch; anything at or past the end of memory reads as zero.
  always_comb begin
    addr = 64'd0;
    for (int i = 0; i < NBYTES; i++) begin
      addr     = PC + 64'(i);
      oob[i]   = (addr >= 64'(IMEM_BYTES));
      ibyte[i] = oob[i] ? 8'h00 : imem[{addr[AW-1:0], 3'b000} +: 8];
    end
  end

  always_comb begin
    icode       = ibyte[0][7:4];
    ifun        = ibyte[0][3:0];
    need_regids = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    need_valc   = icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    rA          = need_regids ? ibyte[1][7:4] : RNONE;
    rB          = need_regids ? ibyte[1][3:0] : RNONE;
    valC        = 64'd0;
    if (icode inside {4'h3, 4'h4, 4'h5})
      valC = ibyte[9:2];
    else if (icode inside {4'h7, 4'h8})
      valC = ibyte[8:1];
    valP = PC + 64'd1 + 64'(need_regids) + (need_valc ? 64'd8 : 64'd0);
    ilen = 4'd1 + 4'(need_regids) + (need_valc ? 4'd8 : 4'd0);
    imem_error = 1'b0;
    for (int i = 0; i < NBYTES; i++)
      if ((4'(i) < ilen) && oob[i]) imem_error = 1'b1;
    instr_valid = !((icode > 4'hB) ||
                    ((icode == 4'h6) && (ifun > 4'h3)) ||
                    (((icode == 4'h2) || (icode == 4'h7)) && (ifun > 4'h6)));
    hlt = (icode == 4'h0);
  end

  // Source/destination selection and register reads.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    if (icode inside {4'h2, 4'h4, 4'h6, 4'hA}) src_a = rA;
    else if (icode inside {4'h9, 4'hB})        src_a = RSP;
    if (icode inside {4'h4, 4'h5, 4'h6})             src_b = rB;
    else if (icode inside {4'h8, 4'h9, 4'hA, 4'hB})  src_b = RSP;
    if ((icode == 4'h2 && cnd) || icode == 4'h3 || icode == 4'h6) dst_e = rB;
    else if (icode inside {4'h8, 4'h9, 4'hA, 4'hB})               dst_e = RSP;
    if (icode inside {4'h5, 4'hB}) dst_m = rA;
    valA = (src_a == RNONE) ? 64'd0 : regs[src_a];
    valB = (src_b == RNONE) ? 64'd0 : regs[src_b];
  end

  always_comb begin
    sum     = valB + valA;
    diff    = valB - valA;
    of_next = 1'b0;
    valE    = 64'd0;
    case (icode)
      4'h2:       valE = valA;
      4'h3:       valE = valC;
      4'h4, 4'h5: valE = valB + valC;
      4'h6: begin
        case (ifun)
          4'h0: begin
            valE    = sum;
            of_next = (valA[63] == valB[63]) && (sum[63] != valB[63]);
          end
          4'h1: begin
            valE    = diff;
            of_next = (valA[63] != valB[63]) && (diff[63] != valB[63]);
          end
          4'h2:    valE = valB & valA;
          4'h3:    valE = valB ^ valA;
          default: valE = 64'd0;
        endcase
      end
      4'h8, 4'hA: valE = valB - 64'd8;
      4'h9, 4'hB: valE = valB + 64'd8;
      default:    valE = 64'd0;
    endcase
  end

  // Branch / conditional-move condition.
  always_comb begin
    cnd = 1'b0;
    if (icode == 4'h2 || icode == 4'h7) begin
      case (ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (sf ^ of) | zf;
        4'h2:    cnd = sf ^ of;
        4'h3:    cnd = zf;
        4'h4:    cnd = !zf;
        4'h5:    cnd = !(sf ^ of);
        4'h6:    cnd = !(sf ^ of) && !zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  assign wr_ok = !hlt && instr_valid && !imem_error;

  // Write-back: the M write is issued last so it overrides E on the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= (i == 4) ? RSP_INIT : 64'd0;
      zf <= 1'b1;
      sf <= 1'b0;
      of <= 1'b0;
    end else begin
      if (icode == 4'h6) begin
        zf <= (valE == 64'd0);
        sf <= valE[63];
        of <= of_next;
      end
      if (wr_ok) begin
        if (dst_e != RNONE) regs[dst_e] <= valE;
        if (dst_m != RNONE) regs[dst_m] <= valM;
      end
    end
  end

`ifdef Y86_ALU_DEBUG_EN
  assign alu_valA = valA;
  assign alu_valB = valB;
  assign alu_valC = valC;
`endif

endmodule

// File: tb/tb_y86_fetch_decode_execute.sv
// Directed bench for y86_fetch_decode_execute; expectations queued as each instruction is applied.
module tb_y86_fetch_decode_execute;

  localparam int unsigned IMEM_BYTES = 1024;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [63:0]             PC;
  logic [8*IMEM_BYTES-1:0] imem;
  logic [63:0]             valM;
  logic [3:0]              icode, ifun, rA, rB;
  logic [63:0]             valC, valP, valA, valB, valE;
  logic                    cnd, zf, sf, of, imem_error, instr_valid, hlt;
`ifdef Y86_ALU_DEBUG_EN
  logic signed [63:0]      alu_valA, alu_valB, alu_valC;
`endif

  y86_fetch_decode_execute #(.IMEM_BYTES(IMEM_BYTES), .RSP_INIT(64'd27)) dut (
    .clk(clk), .rst(rst), .PC(PC), .imem(imem), .valM(valM),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .valA(valA), .valB(valB), .valE(valE),
    .cnd(cnd), .zf(zf), .sf(sf), .of(of),
    .imem_error(imem_error), .instr_valid(instr_valid), .hlt(hlt)
`ifdef Y86_ALU_DEBUG_EN
    , .alu_valA(alu_valA), .alu_valB(alu_valB), .alu_valC(alu_valC)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  sb_t sb[$];
  int  pass_cnt = 0;
  int  total    = 0;

  function automatic logic [63:0] probe(input string t);
    case (t)
      "icode":       probe = 64'(icode);
      "ifun":        probe = 64'(ifun);
      "rA":          probe = 64'(rA);
      "rB":          probe = 64'(rB);
      "valC":        probe = valC;
      "valP":        probe = valP;
      "valA":        probe = valA;
      "valB":        probe = valB;
      "valE":        probe = valE;
      "cnd":         probe = 64'(cnd);
      "zf":          probe = 64'(zf);
      "sf":          probe = 64'(sf);
      "of":          probe = 64'(of);
      "imem_error":  probe = 64'(imem_error);
      "instr_valid": probe = 64'(instr_valid);
      "hlt":         probe = 64'(hlt);
      default:       probe = 64'bx;
    endcase
  endfunction

  task automatic want(input string t, input logic [63:0] v);
    sb_t e;
    e.tag = t;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain(input string step);
    sb_t         e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = probe(e.tag);
      total++;
      assert (obs === e.exp) pass_cnt++;
      else $error("FAIL %s.%s: observed %0h expected %0h", step, e.tag, obs, e.exp);
    end
  endtask

  // Place ten instruction bytes (first byte in the top octet) at pc and point PC there.
  task automatic load(input logic [63:0] pc, input logic [79:0] ins);
    logic [79:0] tmp;
    tmp = ins;
    for (int k = 0; k < 10; k++)
      if (pc + 64'(k) < 64'(IMEM_BYTES))
        imem[8*(int'(pc) + k) +: 8] = tmp[79-8*k -: 8];
    PC = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    PC   = 64'd0;
    imem = '0;
    valM = 64'd0;
    #2;
    load(0, 80'h204F_0000_0000_0000_0000);
    want("zf", 1); want("sf", 0); want("of", 0); want("valA", 27);
    drain("reset_rsp");
    load(0, 80'h202F_0000_0000_0000_0000);
    want("valA", 0);
    drain("reset_rdx");
    tick();
    rst = 1'b0;

    // irmovq $10,%rdx
    load(0, 80'h30F2_0A00_0000_0000_0000);
    want("icode", 3); want("ifun", 0); want("rA", 4'hF); want("rB", 2);
    want("valC", 10); want("valP", 10); want("valE", 10);
    want("hlt", 0); want("instr_valid", 1); want("imem_error", 0); want("cnd", 0);
    drain("irmovq");
    tick();
    load(0, 80'h202F_0000_0000_0000_0000);
    want("valA", 10); want("valE", 10); want("cnd", 1); want("valP", 2);
    drain("read_rdx");

    // addq then subq with equal operands
    load(0, 80'h30F3_0A00_0000_0000_0000);
    tick();
    load(0, 80'h6023_0000_0000_0000_0000);
    want("valA", 10); want("valB", 10); want("valE", 20);
    drain("addq");
    tick();
    want("zf", 0); want("sf", 0); want("of", 0);
    drain("addq_cc");
    load(0, 80'h30F3_0A00_0000_0000_0000);
    tick();
    load(0, 80'h6123_0000_0000_0000_0000);
    want("valE", 0);
    drain("subq");
    tick();
    want("zf", 1); want("sf", 0); want("of", 0);
    drain("subq_cc");
    load(0, 80'h7388_7766_5544_3322_1100);
    want("cnd", 1); want("valP", 9); want("valC", 64'h1122_3344_5566_7788);
    drain("je");
    load(0, 80'h7400_0000_0000_0000_0000);
    want("cnd", 0);
    drain("jne");

    // Signed overflow on add
    load(0, 80'h30F2_FFFF_FFFF_FFFF_FF7F);
    tick();
    load(0, 80'h30F3_0100_0000_0000_0000);
    tick();
    load(0, 80'h6023_0000_0000_0000_0000);
    want("valE", 64'h8000_0000_0000_0000);
    drain("addq_ovf");
    tick();
    want("zf", 0); want("sf", 1); want("of", 1);
    drain("ovf_cc");
    load(0, 80'h7200_0000_0000_0000_0000);
    want("cnd", 0);
    drain("jl");
    load(0, 80'h7100_0000_0000_0000_0000);
    want("cnd", 0);
    drain("jle");
    load(0, 80'h7600_0000_0000_0000_0000);
    want("cnd", 1);
    drain("jg");

    // andq / xorq
    load(0, 80'h6223_0000_0000_0000_0000);
    want("valE", 0);
    drain("andq");
    tick();
    want("zf", 1); want("sf", 0); want("of", 0);
    drain("andq_cc");
    load(0, 80'h6323_0000_0000_0000_0000);
    want("valE", 64'h7FFF_FFFF_FFFF_FFFF);
    drain("xorq");
    tick();
    want("zf", 0);
    drain("xorq_cc");

    // Asynchronous reset between clock edges
    load(0, 80'h202F_0000_0000_0000_0000);
    want("valA", 64'h7FFF_FFFF_FFFF_FFFF);
    drain("pre_rst");
    @(negedge clk);
    rst = 1'b1;
    #1;
    want("valA", 0); want("zf", 1); want("sf", 0); want("of", 0);
    drain("async_rst");
    load(0, 80'h204F_0000_0000_0000_0000);
    want("valA", 27);
    drain("async_rst_rsp");
    tick();
    rst = 1'b0;

    // pushq / popq
    load(0, 80'h30F2_0A00_0000_0000_0000);
    tick();
    load(0, 80'hA02F_0000_0000_0000_0000);
    want("valA", 10); want("valB", 27); want("valE", 19); want("valP", 2);
    drain("pushq");
    tick();
    load(0, 80'h204F_0000_0000_0000_0000);
    want("valA", 19);
    drain("pushq_rsp");
    valM = 64'h55;
    load(0, 80'hB06F_0000_0000_0000_0000);
    want("valA", 19); want("valB", 19); want("valE", 27);
    drain("popq");
    tick();
    load(0, 80'h206F_0000_0000_0000_0000);
    want("valA", 64'h55);
    drain("popq_dst");
    load(0, 80'h204F_0000_0000_0000_0000);
    want("valA", 27);
    drain("popq_rsp");
    valM = 64'h1234;
    load(0, 80'hB04F_0000_0000_0000_0000);
    tick();
    load(0, 80'h204F_0000_0000_0000_0000);
    want("valA", 64'h1234);
    drain("popq_rsp_mwins");

    // halt and invalid encodings
    load(0, 80'h30F0_0500_0000_0000_0000);
    tick();
    load(0, 80'h0000_0000_0000_0000_0000);
    want("hlt", 1); want("icode", 0); want("instr_valid", 1); want("valP", 1);
    drain("halt");
    tick();
    load(0, 80'hC000_0000_0000_0000_0000);
    want("instr_valid", 0); want("hlt", 0);
    drain("icode_c");
    load(0, 80'h2700_0000_0000_0000_0000);
    want("instr_valid", 0);
    drain("cmov_f7");
    load(0, 80'h2600_0000_0000_0000_0000);
    want("instr_valid", 1);
    drain("cmov_f6");
    load(0, 80'h6420_0000_0000_0000_0000);
    want("instr_valid", 0);
    drain("opq_f4");
    tick();
    load(0, 80'h200F_0000_0000_0000_0000);
    want("valA", 5);
    drain("invalid_nowrite");

    // Instruction memory boundary
    load(1023, 80'h3000_0000_0000_0000_0000);
    want("imem_error", 1); want("icode", 3); want("rA", 0); want("rB", 0);
    want("valC", 0); want("valP", 1033);
    drain("imem_end");
    tick();
    load(0, 80'h200F_0000_0000_0000_0000);
    want("valA", 5);
    drain("imem_err_nowrite");
    load(1023, 80'h0000_0000_0000_0000_0000);
    want("imem_error", 0); want("hlt", 1);
    drain("halt_last_byte");
    load(1022, 80'h200F_0000_0000_0000_0000);
    want("imem_error", 0); want("valA", 5);
    drain("fits_at_end");
    load(1024, 80'h0000_0000_0000_0000_0000);
    want("imem_error", 1); want("icode", 0);
    drain("pc_past_end");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/y86_fetch_decode_execute.md
Y86_FETCH_DECODE_EXECUTE -- requirements
Module: y86_fetch_decode_execute

Interface
REQ-001 SHALL use a single clock `clk`; reset `rst` is asynchronous and active-high.
REQ-002 Parameter IMEM_BYTES, default 1024, instruction-memory size in bytes.
REQ-003 Parameter RSP_INIT, default 27, reset value of register 4 (%rsp).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 PC  in  64  address of the current instruction.
REQ-007 imem  in  8*IMEM_BYTES  flattened instruction memory; byte i = imem[8i+7:8i].
REQ-008 valM  in  64  memory-stage read data, used for register write-back.
REQ-009 icode, ifun  out  4 each  opcode nibble (byte0[7:4]) and function nibble (byte0[3:0]).
REQ-010 rA, rB  out  4 each  register specifiers (byte1[7:4], byte1[3:0]); 4'hF when absent.
REQ-011 valC  out  64  little-endian constant.
REQ-012 valP  out  64  PC of the next sequential instruction.
REQ-013 valA, valB  out  64  register-file read data.
REQ-014 valE  out  64  ALU result.
REQ-015 cnd  out  1  branch/move condition.
REQ-016 zf, sf, of  out  1 each  condition-code register.
REQ-017 imem_error, instr_valid, hlt  out  1 each  fetch status flags.

Function
REQ-018 Fetch SHALL be combinational from PC; need_regids for icode 2,3,4,5,6,A,B; need_valC for icode 3,4,5 (bytes 2..9) and 7,8 (bytes 1..8).
REQ-019 valP SHALL equal PC + 1 + need_regids + 8*need_valC, with 64-bit wrap.
REQ-020 imem_error SHALL be 1 when any byte of the instruction lies at or beyond IMEM_BYTES; such bytes read as 0.
REQ-021 instr_valid SHALL be 0 when icode > B, when icode 6 has ifun > 3, or when icode 2 or 7 has ifun > 6; otherwise 1.
REQ-022 hlt SHALL be 1 exactly when icode == 0.
REQ-023 Decode source selection:
- srcA = rA for icode 2,4,6,A; 4 for icode 9,B.
- srcB = rB for icode 4,5,6; 4 for icode 8,9,A,B.
- Reads are combinational; absent source (F) reads 0.
REQ-024 valE by icode:
- 2: valA.
- 3: valC.
- 4, 5: valB + valC.
- 6: valB op valA, where ifun 0 = add, 1 = valB - valA, 2 = AND, 3 = XOR.
- 8, A: valB - 8.
- 9, B: valB + 8.
- otherwise: 0.
REQ-025 zf, sf and of SHALL update at the rising clk edge only for icode 6; of uses signed overflow of add/sub and is 0 for AND/XOR.
REQ-026 cnd SHALL be combinational on ifun and the condition codes: 0 always, 1 le (sf^of)|zf, 2 l sf^of, 3 e zf, 4 ne !zf, 5 ge !(sf^of), 6 g !(sf^of)&!zf; cnd = 0 for icodes other than 2 and 7.
REQ-027 Register writes at the rising clk edge:
- dstE = rB for icode 2 (when cnd), 3 and 6; 4 for icode 8,9,A,B.
- dstM = rA for icode 5 and B.
- The M write wins over the E write on the same register.
- No write when hlt, !instr_valid or imem_error.

Reset
REQ-028 While rst is high: zf = 1, sf = 0, of = 0, register 4 = RSP_INIT, all other registers = 0, and no writes occur.

Configuration
REQ-029 With Y86_ALU_DEBUG_EN defined, signed 64-bit outputs alu_valA, alu_valB and alu_valC SHALL expose the ALU operands; without it these ports SHALL be absent and behaviour is otherwise unchanged.

Verification
REQ-030 PC = 0, bytes 30 F2 0A 00.. (irmovq $10,%rdx) -> icode = 3, rB = 2, valC = 10, valP = 10, valE = 10; after clk, reg2 = 10.
REQ-031 With reg2 = 10 and reg3 = 10, subq %rdx,%rbx (61 23) -> valE = 0; after clk, zf = 1 and sf = 0; a following je (73) gives cnd = 1.
REQ-032 pushq %rdx (A0 2F) after reset -> valA = 10, valB = 27, valE = 19; after clk, reg4 = 19.
REQ-033 Byte 00 -> hlt = 1 and no register changes; byte C0 -> instr_valid = 0; PC = IMEM_BYTES-1 holding 30 -> imem_error = 1.
REQ-034 Assert rst mid-program -> registers and condition codes return to their reset values immediately, without waiting for clk.
